// File: rtl/byte_check_pkg.sv
// Shared encodings and next-expected-byte function for the byte pattern checker.
package byte_check_pkg;

    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_INC   = 2'd1,
        MODE_ALT   = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // Reserved encoding 3 behaves as constant mode.
    function automatic mode_e decode_mode(input logic [1:0] m);
        return (m == 2'd3) ? MODE_CONST : mode_e'(m);
    endfunction

    // Values are carried at 32 bits and masked to the data width w.
    function automatic logic [31:0] nxt(input mode_e m, input logic [31:0] x,
                                        input logic [31:0] cfg, input int unsigned w);
        logic [31:0] mask;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case (m)
            MODE_INC: nxt = (x + 32'd1) & mask;
            MODE_ALT: nxt = (~x) & mask;
            default:  nxt = cfg & mask;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/byte_pattern_checker.sv
// Locks onto a constant/incrementing/alternating byte stream, then flags and
// counts mismatches and drops lock after a run of consecutive errors.
module byte_pattern_checker
    import byte_check_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int CNT_W       = 16,
    parameter int LOCK_THRESH = 4,
    parameter int LOSS_THRESH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] cfg_value,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              locked,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  byte_count
);

    localparam int GW = $clog2(LOCK_THRESH + 1);
    localparam int BW = $clog2(LOSS_THRESH + 1);
    localparam logic [GW-1:0] LOCK_V     = GW'(LOCK_THRESH);
    localparam logic [BW-1:0] LOSS_LAST  = BW'(LOSS_THRESH - 1);

    state_e            state_q;
    mode_e             mode_q;
    logic [DATA_W-1:0] cfg_q;
    logic [DATA_W-1:0] exp_q;
    logic [GW-1:0]     good_cnt_q;
    logic [BW-1:0]     bad_run_q;
    logic              locked_q;
    logic              err_pulse_q;

    logic              accept;
    logic              match;
    logic [31:0]       nxt_exp_w;
    logic [31:0]       nxt_in_w;
    logic [GW-1:0]     hunt_good_d;
    logic [DATA_W-1:0] hunt_exp_d;

    assign in_ready  = enable;
    assign accept    = in_valid & enable;
    assign match     = (in_data == exp_q);
    assign nxt_exp_w = nxt(mode_q, 32'(exp_q), 32'(cfg_q), DATA_W);
    assign nxt_in_w  = nxt(mode_q, 32'(in_data), 32'(cfg_q), DATA_W);

    // Hunting either extends the current consistent run or reseeds from this byte.
    always_comb begin
        hunt_good_d = '0;
        hunt_exp_d  = exp_q;
        if ((good_cnt_q != '0) && match) begin
            hunt_good_d = good_cnt_q + 1'b1;
            hunt_exp_d  = nxt_exp_w[DATA_W-1:0];
        end else if (mode_q == MODE_CONST) begin
            hunt_good_d = (in_data == cfg_q) ? GW'(1) : '0;
            hunt_exp_d  = cfg_q;
        end else begin
            hunt_good_d = GW'(1);
            hunt_exp_d  = nxt_in_w[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_CONST;
            cfg_q       <= '0;
            exp_q       <= '0;
            good_cnt_q  <= '0;
            bad_run_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= 1'b0;
            if (!enable) begin
                state_q    <= ST_IDLE;
                locked_q   <= 1'b0;
                good_cnt_q <= '0;
                bad_run_q  <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q    <= ST_HUNT;
                        mode_q     <= decode_mode(mode);
                        cfg_q      <= cfg_value;
                        good_cnt_q <= '0;
                        bad_run_q  <= '0;
                    end
                    ST_HUNT: begin
                        if (accept) begin
                            good_cnt_q <= hunt_good_d;
                            exp_q      <= hunt_exp_d;
                            if (hunt_good_d == LOCK_V) begin
                                state_q   <= ST_LOCKED;
                                locked_q  <= 1'b1;
                                bad_run_q <= '0;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (accept) begin
                            exp_q <= nxt_exp_w[DATA_W-1:0];
                            if (match) begin
                                bad_run_q <= '0;
                            end else begin
                                err_pulse_q <= 1'b1;
                                if (bad_run_q == LOSS_LAST) begin
                                    state_q    <= ST_HUNT;
                                    locked_q   <= 1'b0;
                                    good_cnt_q <= '0;
                                    bad_run_q  <= '0;
                                end else begin
                                    bad_run_q <= bad_run_q + 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (accept && (state_q == ST_LOCKED) && !match),
        .clr_i (clear),
        .cnt_o (err_count)
    );

    sat_counter #(.W(CNT_W)) u_byte_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (accept && ((state_q == ST_HUNT) || (state_q == ST_LOCKED))),
        .clr_i (clear),
        .cnt_o (byte_count)
    );

endmodule

// File: tb/tb_byte_pattern_checker.sv
// Scoreboard bench: each issued byte queues its expected outputs, a monitor checks them after the accept edge.
module tb_byte_pattern_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [1:0] mode;
    logic [7:0] cfg_value;
    logic       clear;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       locked;
    logic       err_pulse;
    logic [3:0] err_count;
    logic [3:0] byte_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       l;
        logic [3:0] e;
        logic [3:0] b;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    byte_pattern_checker #(
        .DATA_W(8), .CNT_W(4), .LOCK_THRESH(4), .LOSS_THRESH(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .cfg_value(cfg_value),
        .clear(clear), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .byte_count(byte_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic clr, input logic p, input logic l,
                        input logic [3:0] e, input logic [3:0] b);
        exp_t x;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        clear    = clr;
        x.d = d; x.p = p; x.l = l; x.e = e; x.b = b;
        sb_q.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            clear    = 1'b0;
        end
    endtask

    // Return to IDLE, load new mode/constant, clear counters, re-enter HUNT.
    task automatic start(input logic [1:0] m, input logic [7:0] c);
        @(negedge clk);
        enable = 1'b0; in_valid = 1'b0; clear = 1'b0;
        @(negedge clk);
        mode = m; cfg_value = c; clear = 1'b1; enable = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    always @(posedge clk) begin
        logic acc;
        exp_t x;
        acc = in_valid & in_ready & rst_n;
        #1;
        if (acc) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_accept: data %0h with empty scoreboard", in_data);
            end else begin
                x = sb_q.pop_front();
                if (err_pulse !== x.p || locked !== x.l || err_count !== x.e || byte_count !== x.b) begin
                    bad++;
                    $display("FAIL byte_%0h: got pulse=%0b lock=%0b err=%0d bytes=%0d want pulse=%0b lock=%0b err=%0d bytes=%0d",
                             x.d, err_pulse, locked, err_count, byte_count, x.p, x.l, x.e, x.b);
                end else begin
                    $display("ok   byte_%0h: pulse=%0b lock=%0b err=%0d bytes=%0d",
                             x.d, err_pulse, locked, err_count, byte_count);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; mode = 2'd0; cfg_value = 8'h00;
        clear = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_locked", locked, 0);
        chk("reset_err_pulse", err_pulse, 0);
        chk("reset_err_count", err_count, 0);
        chk("reset_byte_count", byte_count, 0);
        rst_n = 1'b1;

        // Constant 0xAA: lock on the 4th byte.
        start(2'd0, 8'hAA);
        send(8'hAA, 0, 0, 0, 0, 1);
        send(8'hAA, 0, 0, 0, 0, 2);
        send(8'hAA, 0, 0, 0, 0, 3);
        send(8'hAA, 0, 0, 1, 0, 4);
        // Isolated error, recovery, then three in a row drops lock.
        send(8'hAB, 0, 1, 1, 1, 5);
        send(8'hAA, 0, 0, 1, 1, 6);
        send(8'h00, 0, 1, 1, 2, 7);
        send(8'h00, 0, 1, 1, 3, 8);
        send(8'h00, 0, 1, 0, 4, 9);
        idle(1);

        // Incrementing through the FF->00 wrap; expectation advances over an error.
        start(2'd1, 8'h00);
        send(8'hFE, 0, 0, 0, 0, 1);
        send(8'hFF, 0, 0, 0, 0, 2);
        send(8'h00, 0, 0, 0, 0, 3);
        send(8'h01, 0, 0, 1, 0, 4);
        send(8'h03, 0, 1, 1, 1, 5);
        send(8'h03, 0, 0, 1, 1, 6);
        idle(1);

        // Alternating: lock, lose, relock on a new seed.
        start(2'd2, 8'h00);
        send(8'h55, 0, 0, 0, 0, 1);
        send(8'hAA, 0, 0, 0, 0, 2);
        send(8'h55, 0, 0, 0, 0, 3);
        send(8'hAA, 0, 0, 1, 0, 4);
        send(8'h12, 0, 1, 1, 1, 5);
        send(8'h12, 0, 1, 1, 2, 6);
        send(8'h12, 0, 1, 0, 3, 7);
        send(8'h0F, 0, 0, 0, 3, 8);
        send(8'hF0, 0, 0, 0, 3, 9);
        send(8'h0F, 0, 0, 0, 3, 10);
        send(8'hF0, 0, 0, 1, 3, 11);
        idle(1);

        // Saturation of both 4-bit counters, then clear racing a mismatch.
        start(2'd0, 8'hAA);
        send(8'hAA, 0, 0, 0, 0, 1);
        send(8'hAA, 0, 0, 0, 0, 2);
        send(8'hAA, 0, 0, 0, 0, 3);
        send(8'hAA, 0, 0, 1, 0, 4);
        for (int i = 1; i <= 20; i++) begin
            send(8'h00, 0, 1, 1, 4'((i > 15) ? 15 : i), 4'((4 + 2 * i - 1 > 15) ? 15 : 4 + 2 * i - 1));
            send(8'hAA, 0, 0, 1, 4'((i > 15) ? 15 : i), 4'((4 + 2 * i > 15) ? 15 : 4 + 2 * i));
        end
        send(8'h00, 1, 1, 1, 0, 0);
        send(8'hAA, 0, 0, 1, 0, 1);
        idle(1);

        // Enable drop: ready falls combinationally, lock next edge, counters hold.
        @(negedge clk);
        enable = 1'b0;
        #1;
        chk("disable_in_ready", in_ready, 0);
        chk("disable_locked_still", locked, 1);
        @(posedge clk);
        #1;
        chk("disable_locked", locked, 0);
        chk("disable_err_hold", err_count, 0);
        chk("disable_bytes_hold", byte_count, 1);

        // Asynchronous reset mid-stream clears everything before the next edge.
        start(2'd0, 8'hAA);
        send(8'hAA, 0, 0, 0, 0, 1);
        send(8'hAA, 0, 0, 0, 0, 2);
        send(8'hAA, 0, 0, 0, 0, 3);
        send(8'hAA, 0, 0, 1, 0, 4);
        send(8'h00, 0, 1, 1, 1, 5);
        idle(1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_locked", locked, 0);
        chk("async_rst_err_pulse", err_pulse, 0);
        chk("async_rst_err_count", err_count, 0);
        chk("async_rst_byte_count", byte_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
